// File: rtl/mem_burst_master.sv
// Burst initiator for the single-port 16-bit halfword memory, with a 4-entry return FIFO.
// Optional `done` pulse output when MEM_BURST_MASTER_DONE_EN is defined.
//
// state   | meaning
// S_IDLE  | waiting for a command, cmd_ready high
// S_WR    | accepting write beats, one memory write per wr_valid
// S_RD    | issuing reads while fewer than 4 are outstanding
// S_DRAIN | all reads issued, waiting for the return FIFO to empty
module mem_burst_master #(
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [15:0]           wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [15:0]           rd_data,
    output logic                  busy,
    output logic                  mem_en,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_din,
    input  logic [15:0]           mem_dout
`ifdef MEM_BURST_MASTER_DONE_EN
    ,
    output logic                  done
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  beat_q;
    logic                  load, adv;
    logic                  iss_q;
    logic [15:0]           fifo_q [4];
    logic [1:0]            wr_ptr_q, rd_ptr_q;
    logic [2:0]            cnt_q, cnt_d, outstanding;
    logic                  push, pop;

    // A read issued last cycle has its data on mem_dout now, so it is captured this cycle.
    assign push        = iss_q;
    assign pop         = rd_valid && rd_ready;
    assign cnt_d       = cnt_q + {2'b00, push} - {2'b00, pop};
    assign outstanding = cnt_q + {2'b00, iss_q};

    assign rd_valid  = (cnt_q != 3'd0);
    assign rd_data   = rd_valid ? fifo_q[rd_ptr_q] : 16'h0000;
    assign busy      = (state_q != S_IDLE);
    assign mem_en    = mem_wr_en | mem_rd_en;
    assign mem_addr  = mem_en ? addr_q : '0;
    assign mem_din   = (state_q == S_WR) ? wr_data : 16'h0000;

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        load      = 1'b0;
        adv       = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    load    = 1'b1;
                    state_d = cmd_write ? S_WR : S_RD;
                end
            end
            S_WR: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    mem_wr_en = 1'b1;
                    adv       = 1'b1;
                    if (beat_q == '0) state_d = S_IDLE;
                end
            end
            S_RD: begin
                // A pop in this cycle does not count toward freeing a slot.
                if (outstanding < 3'd4) begin
                    mem_rd_en = 1'b1;
                    adv       = 1'b1;
                    if (beat_q == '0) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!iss_q && cnt_d == 3'd0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            beat_q   <= '0;
            iss_q    <= 1'b0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            cnt_q    <= 3'd0;
            for (int i = 0; i < 4; i++) fifo_q[i] <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (load) begin
                addr_q <= cmd_addr;
                beat_q <= cmd_len;
            end else if (adv) begin
                addr_q <= addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                beat_q <= beat_q - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
            end
            iss_q <= mem_rd_en;
            if (push) begin
                fifo_q[wr_ptr_q] <= mem_dout;
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            cnt_q <= cnt_d;
        end
    end

`ifdef MEM_BURST_MASTER_DONE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done <= 1'b0;
        else        done <= (state_q != S_IDLE) && (state_d == S_IDLE);
    end
`endif

endmodule

// File: tb/tb_mem_burst_master.sv
// Self-checking bench for mem_burst_master: vector table, hand-written corner sequences,
// and randomized write/read-back pairs checked against an array model of memory contents.
module tb_mem_burst_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [11:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid, wr_ready;
    logic [15:0] wr_data;
    logic        rd_valid, rd_ready;
    logic [15:0] rd_data;
    logic        busy, mem_en, mem_rd_en, mem_wr_en;
    logic [11:0] mem_addr;
    logic [15:0] mem_din, mem_dout;
`ifdef MEM_BURST_MASTER_DONE_EN
    logic        done;
`endif

    always #5 clk = ~clk;

    mem_burst_master dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .mem_en(mem_en), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
`ifdef MEM_BURST_MASTER_DONE_EN
        , .done(done)
`endif
    );

    // Memory with registered read, plus the bench's expectation of its contents.
    logic [15:0] mem     [4096];
    logic [15:0] ref_mem [4096];
    always @(posedge clk) begin
        if (mem_en && mem_wr_en) mem[mem_addr] <= mem_din;
        if (mem_en && mem_rd_en) mem_dout <= mem[mem_addr];
    end

    int gcyc = 0;
    always @(posedge clk) gcyc <= gcyc + 1;

    int acc_addr[$], acc_wr[$], acc_cyc[$], acc_dat[$], rx_dat[$], rx_cyc[$];
    int inv_err = 0;
    always @(negedge clk) begin
        if (mem_en) begin
            acc_addr.push_back(int'(mem_addr));
            acc_wr.push_back(int'(mem_wr_en));
            acc_cyc.push_back(gcyc);
            acc_dat.push_back(int'(mem_din));
        end
        if (rd_valid && rd_ready) begin
            rx_dat.push_back(int'(rd_data));
            rx_cyc.push_back(gcyc);
        end
        if ((mem_rd_en && mem_wr_en) || (mem_en != (mem_rd_en | mem_wr_en))) inv_err++;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int get_done();
`ifdef MEM_BURST_MASTER_DONE_EN
        return int'(done);
`else
        return 0;
`endif
    endfunction

    task automatic clear_mon();
        acc_addr.delete(); acc_wr.delete(); acc_cyc.delete(); acc_dat.delete();
        rx_dat.delete(); rx_cyc.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 with the DUT back in IDLE.
    task automatic run_burst(input bit w, input int addr, input int len, input int dbase,
                             input int mode, output int rdy_cyc, output int t1,
                             output int dn_at, output int dn_prev, output int dn_after);
        int beat, prev_dn, cur_dn;
        beat = 0; rdy_cyc = -1; prev_dn = 0; dn_at = 0; dn_prev = 0; dn_after = 0;
        clear_mon();
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = 12'(addr); cmd_len = 8'(len);
        @(posedge clk); #1;
        t1 = gcyc;
        cmd_valid = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (w) begin
                wr_valid = (beat <= len) && (mode == 0 || $urandom_range(0, 1) == 1);
                wr_data  = 16'(dbase + beat);
            end else begin
                rd_ready = (mode == 0) || ($urandom_range(0, 1) == 1);
            end
            @(negedge clk);
            cur_dn = get_done();
            if (cmd_ready) begin
                rdy_cyc = c; dn_at = cur_dn; dn_prev = prev_dn;
                break;
            end
            prev_dn = cur_dn;
            if (w && wr_valid && wr_ready) beat++;
            @(posedge clk); #1;
        end
        wr_valid = 1'b0; rd_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        dn_after = get_done();
        @(posedge clk); #1;
    endtask

    task automatic check_burst(input bit w, input int addr, input int len, input int dbase,
                               input bit full, input int t1, input string tag);
        int n;
        bit ok;
        n = len + 1;
        chk({tag, "_acc_count"}, acc_addr.size(), n);
        if (acc_addr.size() == n) begin
            ok = 1;
            for (int i = 0; i < n; i++)
                if (acc_addr[i] != (addr + i) % 4096 || acc_wr[i] != int'(w)) ok = 0;
            chk({tag, "_addr_seq"}, int'(ok), 1);
            if (w) begin
                ok = 1;
                for (int i = 0; i < n; i++)
                    if (acc_dat[i] != ((dbase + i) & 16'hFFFF)) ok = 0;
                chk({tag, "_wr_data"}, int'(ok), 1);
            end
            if (full) begin
                ok = (acc_cyc[0] == t1);
                for (int i = 1; i < n; i++) if (acc_cyc[i] != acc_cyc[0] + i) ok = 0;
                chk({tag, "_acc_timing"}, int'(ok), 1);
            end
        end
        if (!w) begin
            chk({tag, "_rx_count"}, rx_dat.size(), n);
            if (rx_dat.size() == n) begin
                ok = 1;
                for (int i = 0; i < n; i++)
                    if (rx_dat[i] != int'(ref_mem[(addr + i) % 4096])) ok = 0;
                chk({tag, "_rx_data"}, int'(ok), 1);
                if (full && acc_cyc.size() > 0) begin
                    ok = (rx_cyc[0] == acc_cyc[0] + 2);
                    for (int i = 1; i < n; i++) if (rx_cyc[i] != rx_cyc[0] + i) ok = 0;
                    chk({tag, "_rx_timing"}, int'(ok), 1);
                end
            end
        end
    endtask

    task automatic model_write(input int addr, input int len, input int dbase);
        for (int i = 0; i <= len; i++) ref_mem[(addr + i) % 4096] = 16'(dbase + i);
    endtask

    task automatic wait_ready(input string tag);
        int got;
        got = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (cmd_ready) begin got = 1; break; end
        end
        chk({tag, "_ready_timeout"}, got, 1);
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit w;
        int addr;
        int len;
        int dbase;
        int exp_cycles;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc, t1, dn_at, dn_prev, dn_after;
        int a, l, d;

        vecs[0] = '{1'b1, 'h010, 3, 'hA001, 5};
        vecs[1] = '{1'b0, 'h010, 3, 0,      7};
        vecs[2] = '{1'b1, 'hFFE, 2, 'hB001, 4};
        vecs[3] = '{1'b0, 'hFFE, 2, 0,      6};
        vecs[4] = '{1'b1, 'h100, 0, 'h1234, 2};
        vecs[5] = '{1'b0, 'h100, 0, 0,      4};
        vecs[6] = '{1'b1, 'h200, 7, 'hC000, 9};
        vecs[7] = '{1'b0, 'h200, 7, 0,      11};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        #12;
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_mem_en", int'(mem_en), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_wr_ready", int'(wr_ready), 0);
        chk("rst_done", get_done(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full-throughput vector table
        for (int v = 0; v < 8; v++) begin
            run_burst(vecs[v].w, vecs[v].addr, vecs[v].len, vecs[v].dbase, 0,
                      rc, t1, dn_at, dn_prev, dn_after);
            chk($sformatf("vec%0d_ready_cycles", v), rc, vecs[v].exp_cycles);
            check_burst(vecs[v].w, vecs[v].addr, vecs[v].len, vecs[v].dbase, 1'b1, t1,
                        $sformatf("vec%0d", v));
            if (vecs[v].w) model_write(vecs[v].addr, vecs[v].len, vecs[v].dbase);
`ifdef MEM_BURST_MASTER_DONE_EN
            chk($sformatf("vec%0d_done_at_ready", v), dn_at, 1);
            chk($sformatf("vec%0d_done_before", v), dn_prev, 0);
            chk($sformatf("vec%0d_done_after", v), dn_after, 0);
`endif
        end

        // Backpressure: 8-beat read with the consumer stalled
        clear_mon();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h200; cmd_len = 8'd7;
        @(posedge clk); #1;
        cmd_valid = 1'b0; rd_ready = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("bp_issued", acc_addr.size(), 4);
        chk("bp_rd_valid", int'(rd_valid), 1);
        chk("bp_head", int'(rd_data), int'(ref_mem['h200]));
        chk("bp_busy", int'(cmd_ready), 0);
        @(posedge clk); #1;
        rd_ready = 1'b1;
        wait_ready("bp");
        rd_ready = 1'b0;
        check_burst(1'b0, 'h200, 7, 0, 1'b0, 0, "bp");
        if (acc_cyc.size() == 8 && rx_cyc.size() > 0)
            chk("bp_resume", acc_cyc[4], rx_cyc[0] + 1);

        // Write with gaps: 2 beats, wr_valid 1,0,1
        clear_mon();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h300; cmd_len = 8'd1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 16'hD001;
        @(negedge clk);
        chk("gap_wr1", int'(mem_wr_en), 1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        @(negedge clk);
        chk("gap_idle_wr_en", int'(mem_wr_en), 0);
        chk("gap_busy1", int'(cmd_ready), 0);
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_data = 16'hD002;
        @(negedge clk);
        chk("gap_wr2", int'(mem_wr_en), 1);
        chk("gap_busy2", int'(cmd_ready), 0);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        @(negedge clk);
        chk("gap_ready", int'(cmd_ready), 1);
        @(posedge clk); #1;
        check_burst(1'b1, 'h300, 1, 'hD001, 1'b0, 0, "gap");
        if (acc_cyc.size() == 2) chk("gap_spacing", acc_cyc[1] - acc_cyc[0], 2);
        model_write('h300, 1, 'hD001);
        run_burst(1'b0, 'h300, 1, 0, 0, rc, t1, dn_at, dn_prev, dn_after);
        check_burst(1'b0, 'h300, 1, 0, 1'b1, t1, "gap_rb");

        // Reset in the middle of an 8-beat read
        clear_mon();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h200; cmd_len = 8'd7;
        @(posedge clk); #1;
        cmd_valid = 1'b0; rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("mid_pre_rd_valid", int'(rd_valid), 1);
        chk("mid_pre_mem_en", int'(mem_en), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_en", int'(mem_en), 0);
        chk("mid_rst_rd_en", int'(mem_rd_en), 0);
        chk("mid_rst_rd_valid", int'(rd_valid), 0);
        chk("mid_rst_cmd_ready", int'(cmd_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1; rd_ready = 1'b0;
        @(negedge clk);
        chk("mid_post_cmd_ready", int'(cmd_ready), 1);
        chk("mid_post_rd_valid", int'(rd_valid), 0);
        @(posedge clk); #1;
        run_burst(1'b0, 'h010, 3, 0, 0, rc, t1, dn_at, dn_prev, dn_after);
        chk("mid_new_ready_cycles", rc, 7);
        check_burst(1'b0, 'h010, 3, 0, 1'b1, t1, "mid_new");

        // Randomized write/read-back pairs with random gaps and stalls
        for (int k = 0; k < 12; k++) begin
            a = $urandom_range(0, 4095);
            l = $urandom_range(0, 15);
            d = $urandom_range(0, 65535);
            run_burst(1'b1, a, l, d, 1, rc, t1, dn_at, dn_prev, dn_after);
            chk($sformatf("rnd%0d_wr_done", k), int'(rc > 0), 1);
            check_burst(1'b1, a, l, d, 1'b0, 0, $sformatf("rnd%0d_wr", k));
            model_write(a, l, d);
            run_burst(1'b0, a, l, 0, 1, rc, t1, dn_at, dn_prev, dn_after);
            chk($sformatf("rnd%0d_rd_done", k), int'(rc > 0), 1);
            check_burst(1'b0, a, l, 0, 1'b0, 0, $sformatf("rnd%0d_rd", k));
        end

        chk("mem_ctrl_invariants", inv_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
